// File: rtl/counter_pkg.sv
// Shared defaults for the counter timebase.
package counter_pkg;
  localparam int COUNTER_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/counter.sv
// Free-running WIDTH-bit up-counter with synchronous clear; wraps silently.
// Latency: count updates one edge after inputs; no handshake, never stalls.
module counter
  import counter_pkg::*;
#(
  parameter int              WIDTH       = COUNTER_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Reset wins over increment; the add truncates to WIDTH bits for wrap.
  always_ff @(posedge clk) begin
    if (reset) count_q <= RESET_VALUE;
    else       count_q <= count_q + WIDTH'(1);
  end

  assign count = count_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed table, mid-cycle reset pulse, random reset traffic.
module tb_counter;
  localparam int WIDTH = 4;
  localparam logic [WIDTH-1:0] RV = '0;
  localparam int MODV = 1 << WIDTH;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] count;

  int n_cmp;
  int n_bad;

  counter #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .clk  (clk),
    .reset(reset),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: edges since the most recent reset edge; -1 means never reset.
  int since;
  initial since = -1;
  always @(posedge clk) begin
    if (reset)          since <= 0;
    else if (since >= 0) since <= since + 1;
  end

  function automatic logic [WIDTH-1:0] model_count();
    return WIDTH'((int'(RV) + since) % MODV);
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: count=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic             rst;
    int               edges;
    logic [WIDTH-1:0] exp;
    string            name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, count=%0d", count);
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] held;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;

    vecs.push_back('{1'b1,  1, 4'd0,  "reset_first_edge"});
    vecs.push_back('{1'b0,  1, 4'd1,  "first_after_release"});
    vecs.push_back('{1'b0,  9, 4'd10, "count_to_10"});
    vecs.push_back('{1'b1,  1, 4'd0,  "reset_mid_count"});
    vecs.push_back('{1'b0,  1, 4'd1,  "resume_after_reset"});
    vecs.push_back('{1'b0, 14, 4'd15, "reach_all_ones"});
    vecs.push_back('{1'b0,  1, 4'd0,  "wrap_to_zero"});
    vecs.push_back('{1'b0,  4, 4'd4,  "count_after_wrap"});
    vecs.push_back('{1'b1,  3, 4'd0,  "reset_held_3"});
    vecs.push_back('{1'b0, 15, 4'd15, "all_ones_again"});
    vecs.push_back('{1'b1,  1, 4'd0,  "reset_at_all_ones"});
    vecs.push_back('{1'b0,  1, 4'd1,  "resume_from_all_ones_reset"});

    // Each step drives reset, lets the given number of edges pass, samples at the falling edge.
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      repeat (vecs[i].edges) @(posedge clk);
      @(negedge clk);
      check(vecs[i].name, count, vecs[i].exp);
    end

    // Reset pulse that never overlaps a rising edge must not disturb the count.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    held = count;
    check("pre_pulse", count, 4'd4);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1 check("mid_cycle_reset_no_effect", count, held);
    @(negedge clk);
    check("after_mid_cycle_pulse", count, held + 4'd1);
    check("model_agrees_after_pulse", count, model_count());

    // Random reset traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      check("random_vs_model", count, model_count());
    end

    // Long run without reset covers several wraps.
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("long_run_vs_model", count, model_count());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
